shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift controller for the CPU's shift unit. Accepts one shift request (SLL or SRA, 32-bit operand, 5-bit amount) and sequences it through the power-of-two shift stages (1, 2, 4, 8, 16), applying at most one stage per cycle to a working register. It provides a start/ready handshake to the multdiv-style execute stage and frees the datapath from a full single-cycle barrel shifter.

## Interface
Parameters:
- none (width fixed at 32, amount fixed at 5 bits)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- ctrl_start  in  1  request pulse; sampled only in IDLE
- ctrl_op  in  1  0 = SLL (zero fill), 1 = SRA (sign fill from bit 31)
- data_operandA  in  32  value to shift, captured when start is accepted
- ctrl_shiftamt  in  5  shift amount 0..31, captured when start is accepted
- data_result  out  32  shifted value; held until next accepted start
- data_resultRDY  out  1  one-cycle pulse: data_result valid
- busy  out  1  high from accepted start until the cycle data_resultRDY is high, inclusive

## Operation
- Registers: work[31:0], amt_rem[4:0], stage[2:0], op, state.
- States: IDLE, SHIFT, DONE.
- IDLE: if ctrl_start=1, capture work<=data_operandA, amt_rem<=ctrl_shiftamt, op<=ctrl_op, stage<=0; go to SHIFT. ctrl_start=0: stay.
- SHIFT: per cycle handle stage k=stage; if amt_rem[k]=1, work<=work shifted by 2^k (SLL: left, zero fill; SRA: right, fill with work[31]); clear amt_rem[k]; stage<=k+1. After k=4 go to DONE, data_result<=final work.
- DONE: data_resultRDY=1, busy=1 for this one cycle; next edge go to IDLE.
- ctrl_start in SHIFT/DONE is ignored (no queueing); captured inputs are not re-sampled.
- Shifted-out bits discarded; no overflow/carry flag.
- Reset (any state, including mid-SHIFT): state<=IDLE, work/amt_rem/stage/op<=0, data_result=0, data_resultRDY=0, busy=0. In-flight request is dropped with no RDY pulse.

## Timing
- Edge E0: start accepted in IDLE. busy=1 from the cycle after E0.
- Default build: SHIFT occupies exactly 5 cycles (E1..E5 apply stages 0..4); state=DONE after E5; data_resultRDY=1 in the cycle after E5; IDLE after E6. Start-to-RDY latency: 6 cycles, independent of amount.
- data_result updates only on the E5-equivalent edge (entry to DONE); stable otherwise.
- Back-to-back: new start may be asserted in the cycle after RDY (IDLE); a start asserted during the RDY cycle is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SHIFT_SEQ_SKIP_EN defined: zero-bit stages are skipped. Each SHIFT cycle applies the lowest set bit of amt_rem and clears it; SHIFT exits to DONE when amt_rem becomes 0. If captured amount is 0, IDLE goes directly to DONE (data_result<=operand, RDY in the cycle after E0). Latency = popcount(amount) + 1 cycles (1..6).
- Not defined: fixed 5-cycle SHIFT as above; stage counter always walks 0..4.
- Result values identical in both builds.

## Test plan
- SRA 0x80000000 by 4 -> data_result 0xF8000000; default RDY 6 cycles after start, SKIP_EN 2 cycles.
- SLL 0x00000001 by 31 -> 0x80000000; RDY at 6 cycles in both builds; busy high exactly 6 cycles.
- SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF; SRA 0xF0000000 by 31 -> 0xFFFFFFFF.
- Amount 0, operand 0x12345678 -> 0x12345678; default 6 cycles, SKIP_EN 1 cycle.
- Start SLL 0x1 by 3, then pulse start with 0xFFFFFFFF by 1 at cycle 2 and during RDY cycle -> both ignored, result 0x00000008, single RDY pulse.
- Assert reset at cycle 3 of a shift -> next cycle busy=0, data_result=0, no RDY pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the execute stage and shift_sequencer.
// master = requester (execute stage), slave = shift_sequencer.
interface shift_sequencer_if;
  logic        ctrl_start;
  logic        ctrl_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_start, ctrl_op, data_operandA, ctrl_shiftamt,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, ctrl_op, data_operandA, ctrl_shiftamt,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA sequencer: applies power-of-two stages (1,2,4,8,16), one per cycle.
// Optional build macro SHIFT_SEQ_SKIP_EN: skip zero-bit stages (latency popcount(amt)+1).
module shift_sequencer (
  input  logic              clock,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  amt_rem_q, amt_rem_d;
  logic [2:0]  stage_q, stage_d;
  logic        op_q, op_d;
  logic        rdy_q, busy_q;

`ifdef SHIFT_SEQ_SKIP_EN
  logic        found;
  logic [2:0]  k_sel;
`endif

  function automatic logic [31:0] apply_stage(input logic [31:0] w,
                                               input logic [2:0]  k,
                                               input logic        sra);
    logic [4:0] n;
    n = 5'(1) << k;
    if (sra)
      return 32'($signed(w) >>> n);
    else
      return w << n;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      result_q  <= '0;
      amt_rem_q <= '0;
      stage_q   <= '0;
      op_q      <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      result_q  <= result_d;
      amt_rem_q <= amt_rem_d;
      stage_q   <= stage_d;
      op_q      <= op_d;
      // Flags follow the next state so they are flops aligned with state_q.
      rdy_q     <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    result_d  = result_q;
    amt_rem_d = amt_rem_q;
    stage_d   = stage_q;
    op_d      = op_q;
`ifdef SHIFT_SEQ_SKIP_EN
    found     = 1'b0;
    k_sel     = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ctrl_start) begin
          work_d    = bus.data_operandA;
          amt_rem_d = bus.ctrl_shiftamt;
          op_d      = bus.ctrl_op;
          stage_d   = '0;
`ifdef SHIFT_SEQ_SKIP_EN
          if (bus.ctrl_shiftamt == '0) begin
            state_d  = DONE;
            result_d = bus.data_operandA;
          end else begin
            state_d  = SHIFT;
          end
`else
          state_d   = SHIFT;
`endif
        end
      end

      SHIFT: begin
`ifdef SHIFT_SEQ_SKIP_EN
        // Bits below stage_q are already cleared, so this finds the lowest set bit.
        for (int unsigned k = 0; k < 5; k++) begin
          if (!found && (k >= 32'(stage_q)) && amt_rem_q[k]) begin
            found = 1'b1;
            k_sel = 3'(k);
          end
        end
        if (found) begin
          work_d    = apply_stage(work_q, k_sel, op_q);
          amt_rem_d = amt_rem_q & ~(5'(1) << k_sel);
          stage_d   = k_sel + 3'd1;
        end
        if (amt_rem_d == '0) begin
          state_d  = DONE;
          result_d = work_d;
        end
`else
        if (amt_rem_q[stage_q]) begin
          work_d             = apply_stage(work_q, stage_q, op_q);
          amt_rem_d[stage_q] = 1'b0;
        end
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) begin
          state_d  = DONE;
          result_d = work_d;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, hand-written
// corner sequences (ignored starts, mid-shift reset) and randomized requests.
module tb_shift_sequencer;

  logic clock;
  logic reset;
  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [31:0] exp_res;
    int          lat_def;
    int          lat_skip;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a, input logic [4:0] amt);
    if (op)
      return 32'($signed(a) >>> amt);
    else
      return a << amt;
  endfunction

  function automatic int ref_lat(input logic [4:0] amt);
`ifdef SHIFT_SEQ_SKIP_EN
    return $countones(amt) + 1;
`else
    return 6;
`endif
  endfunction

  // Call at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic do_req(input logic op, input logic [31:0] a, input logic [4:0] amt,
                        output logic [31:0] res, output int lat,
                        output int rdy_cnt, output int busy_cnt);
    bus.ctrl_start    = 1'b1;
    bus.ctrl_op       = op;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = amt;
    @(posedge clock); #1;
    bus.ctrl_start    = 1'b0;
    bus.ctrl_op       = 1'($urandom);
    bus.data_operandA = $urandom;
    bus.ctrl_shiftamt = 5'($urandom);
    res = 'x; lat = -1; rdy_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (lat < 0) begin
          lat = c;
          res = bus.data_result;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] res;
    int lat, rdy_cnt, busy_cnt, exp_l, ign_lat;
    logic        r_op;
    logic [31:0] r_a;
    logic [4:0]  r_amt;

    vecs[0] = '{1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 6, 2};
    vecs[1] = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 6, 6};
    vecs[2] = '{1'b1, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 6, 2};
    vecs[3] = '{1'b1, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF, 6, 6};
    vecs[4] = '{1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, 6, 1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 6, 2};
    vecs[6] = '{1'b1, 32'h1234_5678, 5'd8,  32'h0012_3456, 6, 2};
    vecs[7] = '{1'b0, 32'hA5A5_A5A5, 5'd5,  32'hB4B4_B4A0, 6, 3};

    reset = 1'b1;
    bus.ctrl_start = 1'b0;
    bus.ctrl_op = 1'b0;
    bus.data_operandA = '0;
    bus.ctrl_shiftamt = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("rst_result", bus.data_result, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_SEQ_SKIP_EN
      exp_l = vecs[i].lat_skip;
`else
      exp_l = vecs[i].lat_def;
`endif
      do_req(vecs[i].op, vecs[i].a, vecs[i].amt, res, lat, rdy_cnt, busy_cnt);
      check($sformatf("tbl_res[%0d]", i), res, vecs[i].exp_res);
      check($sformatf("tbl_lat[%0d]", i), 32'(lat), 32'(exp_l));
      check($sformatf("tbl_rdy_pulses[%0d]", i), 32'(rdy_cnt), 32'd1);
      check($sformatf("tbl_busy_cycles[%0d]", i), 32'(busy_cnt), 32'(exp_l));
      check($sformatf("tbl_hold[%0d]", i), bus.data_result, vecs[i].exp_res);
    end

    // Starts during SHIFT (cycle 2) and during the RDY cycle must be ignored.
    ign_lat = ref_lat(5'd3);
    bus.ctrl_start = 1'b1; bus.ctrl_op = 1'b0;
    bus.data_operandA = 32'h1; bus.ctrl_shiftamt = 5'd3;
    @(posedge clock); #1;
    rdy_cnt = 0; lat = -1; res = 'x;
    for (int c = 1; c <= 10; c++) begin
      bus.ctrl_start    = (c == 2) || (c == ign_lat);
      bus.data_operandA = 32'hFFFF_FFFF;
      bus.ctrl_shiftamt = 5'd1;
      @(negedge clock);
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (lat < 0) begin lat = c; res = bus.data_result; end
      end
      @(posedge clock); #1;
    end
    bus.ctrl_start = 1'b0;
    check("ign_result", res, 32'h0000_0008);
    check("ign_lat", 32'(lat), 32'(ign_lat));
    check("ign_rdy_pulses", 32'(rdy_cnt), 32'd1);
    check("ign_idle_busy", 32'(bus.busy), 32'd0);
    check("ign_hold", bus.data_result, 32'h0000_0008);

    // Reset asserted in cycle 3 of a shift drops the request.
    bus.ctrl_start = 1'b1; bus.ctrl_op = 1'b0;
    bus.data_operandA = 32'h1; bus.ctrl_shiftamt = 5'd31;
    @(posedge clock); #1;
    bus.ctrl_start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("mid_rst_result", bus.data_result, 32'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.data_resultRDY) rdy_cnt++;
    end
    check("mid_rst_no_rdy", 32'(rdy_cnt), 32'd0);
    @(posedge clock); #1;
    do_req(1'b1, 32'h8000_0000, 5'd4, res, lat, rdy_cnt, busy_cnt);
    check("post_rst_res", res, 32'hF800_0000);
    check("post_rst_lat", 32'(lat), 32'(ref_lat(5'd4)));
    check("post_rst_rdy_pulses", 32'(rdy_cnt), 32'd1);

    for (int i = 0; i < 40; i++) begin
      r_op  = 1'($urandom);
      r_a   = $urandom;
      r_amt = 5'($urandom_range(0, 31));
      do_req(r_op, r_a, r_amt, res, lat, rdy_cnt, busy_cnt);
      check($sformatf("rnd_res[%0d] op=%0d a=%h amt=%0d", i, r_op, r_a, r_amt),
            res, ref_shift(r_op, r_a, r_amt));
      check($sformatf("rnd_lat[%0d]", i), 32'(lat), 32'(ref_lat(r_amt)));
      check($sformatf("rnd_rdy_pulses[%0d]", i), 32'(rdy_cnt), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
